// File: rtl/uart_pkg.sv
// Shared constants and FSM encoding for the UART transmit feeder.
// The guard timeout bounds how long we wait for a transmitter that never reports busy.
package uart_pkg;

   localparam int DEPTH_DEF = 16;
   localparam int AW_DEF    = 4;
   localparam int TIMEOUT   = 4;
   localparam int TMR_W     = 2;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LAUNCH    = 2'd1,
      WAIT_BUSY = 2'd2,
      WAIT_DONE = 2'd3
   } feeder_state_t;

endpackage

// File: rtl/uart_fifo.sv
// Byte FIFO with count-based full/empty and a sticky overflow flag.
// A push while full is dropped even if a pop happens on the same edge.
module uart_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int AW    = AW_DEF
) (
   input  logic          clock,
   input  logic          fpga_power_good,
   input  logic [7:0]    din,
   input  logic          push,
   input  logic          pop,
   input  logic          ovf_clr,
   output logic [7:0]    dout,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count,
   output logic          overflow
);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          push_ok;
   logic          pop_ok;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // Storage is left unreset; validity is tracked entirely by count.
   always_ff @(posedge clock) begin
      if (push_ok) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clock or negedge fpga_power_good) begin
      if (!fpga_power_good) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push_ok, pop_ok})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
         if (push && full) begin
            overflow <= 1'b1;
         end else if (ovf_clr) begin
            overflow <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/uart_tx_feeder.sv
// Drains a byte FIFO into a UART transmitter, one write strobe per byte,
// pacing on the transmitter's busy handshake with a guard timeout.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | waiting for a queued byte and a free transmitter
// LAUNCH    | tx_wr_en high for one cycle with the popped byte on tx_din
// WAIT_BUSY | waiting for tx_busy to rise; gives up after TIMEOUT cycles
// WAIT_DONE | waiting for tx_busy to fall
module uart_tx_feeder
   import uart_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int AW    = AW_DEF
) (
   input  logic          clock,
   input  logic          fpga_power_good,
   input  logic [7:0]    din,
   input  logic          push,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count,
   output logic          overflow,
   input  logic          ovf_clr,
   output logic [7:0]    tx_din,
   output logic          tx_wr_en,
   input  logic          tx_busy
);

   feeder_state_t    state;
   feeder_state_t    state_nxt;
   logic [TMR_W-1:0] tmr;
   logic [TMR_W-1:0] tmr_nxt;
   logic             pop;
   logic [7:0]       fifo_dout;

   uart_fifo #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_fifo (
      .clock           (clock),
      .fpga_power_good (fpga_power_good),
      .din             (din),
      .push            (push),
      .pop             (pop),
      .ovf_clr         (ovf_clr),
      .dout            (fifo_dout),
      .full            (full),
      .empty           (empty),
      .count           (count),
      .overflow        (overflow)
   );

   always_ff @(posedge clock or negedge fpga_power_good) begin
      if (!fpga_power_good) begin
         state  <= IDLE;
         tmr    <= '0;
         tx_din <= 8'h00;
      end else begin
         state <= state_nxt;
         tmr   <= tmr_nxt;
         if (pop) begin
            tx_din <= fifo_dout;
         end
      end
   end

   // tx_wr_en decodes the state register, so reset removes it immediately.
   always_comb begin
      state_nxt = state;
      tmr_nxt   = tmr;
      pop       = 1'b0;
      tx_wr_en  = 1'b0;
      case (state)
         IDLE: begin
            if (!empty && !tx_busy) begin
               pop       = 1'b1;
               state_nxt = LAUNCH;
            end
         end
         LAUNCH: begin
            tx_wr_en  = 1'b1;
            tmr_nxt   = TMR_W'(TIMEOUT - 1);
            state_nxt = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            if (tx_busy) begin
               state_nxt = WAIT_DONE;
            end else if (tmr == '0) begin
               state_nxt = IDLE;
            end else begin
               tmr_nxt = tmr - TMR_W'(1);
            end
         end
         WAIT_DONE: begin
            if (!tx_busy) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule
